frame_sequencer: RTL

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

---
 rtl/frame_sequencer.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/frame_sequencer.sv
// Frame sequencer: emits a fixed header then a payload window, each bit held
// for BIT_CYCLES clocks, followed by a trigger-low gap; optional back-to-back repeat.
module frame_sequencer #(
    parameter int unsigned BIT_CYCLES   = 50,
    parameter int unsigned PRE_BITS     = 16,
    parameter logic [63:0] PRE_PATTERN  = 64'hAAAB,
    parameter int unsigned PAYLOAD_BITS = 144,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic repeat_en,
    input  logic abort,
    output logic trigger,
    output logic sending,
    output logic head,
    output logic datacmd,
    output logic busy,
    output logic frame_done
);

    localparam int unsigned CNT_W  = 16;
    localparam int unsigned PAT_W  = 64;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_BITS - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(PAYLOAD_BITS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    // Header left-aligned so the current bit is always the MSB of the shifter.
    localparam logic [PAT_W-1:0] HDR_INIT = PRE_PATTERN << (PAT_W - PRE_BITS);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2,
        GAP     = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cyc_cnt;
    logic [CNT_W-1:0]   bit_cnt;
    logic [PAT_W-1:0]   hdr_sr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cyc_cnt    <= '0;
            bit_cnt    <= '0;
            hdr_sr     <= '0;
            trigger    <= 1'b0;
            sending    <= 1'b0;
            head       <= 1'b0;
            datacmd    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state   <= HEADER;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        hdr_sr  <= HDR_INIT;
                        trigger <= 1'b1;
                        sending <= 1'b1;
                        head    <= HDR_INIT[PAT_W-1];
                        datacmd <= 1'b0;
                        busy    <= 1'b1;
                    end
                end

                HEADER: begin
                    if (abort) begin
                        state   <= GAP;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        trigger <= 1'b0;
                        sending <= 1'b0;
                        head    <= 1'b0;
                        datacmd <= 1'b0;
                    end else if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == PRE_LAST) begin
                            state   <= PAYLOAD;
                            bit_cnt <= '0;
                            head    <= 1'b0;
                            datacmd <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            hdr_sr  <= hdr_sr << 1;
                            head    <= hdr_sr[PAT_W-2];
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                PAYLOAD: begin
                    // Abort is checked first so it also suppresses frame_done on the last cycle.
                    if (abort) begin
                        state   <= GAP;
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        trigger <= 1'b0;
                        sending <= 1'b0;
                        head    <= 1'b0;
                        datacmd <= 1'b0;
                    end else if (cyc_cnt == BIT_LAST) begin
                        cyc_cnt <= '0;
                        if (bit_cnt == PAY_LAST) begin
                            state      <= GAP;
                            bit_cnt    <= '0;
                            trigger    <= 1'b0;
                            sending    <= 1'b0;
                            datacmd    <= 1'b0;
                            frame_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                GAP: begin
                    if (cyc_cnt == GAP_LAST) begin
                        cyc_cnt <= '0;
                        bit_cnt <= '0;
                        if (repeat_en) begin
                            state   <= HEADER;
                            hdr_sr  <= HDR_INIT;
                            trigger <= 1'b1;
                            sending <= 1'b1;
                            head    <= HDR_INIT[PAT_W-1];
                            datacmd <= 1'b0;
                            busy    <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cyc_cnt <= cyc_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
